// File: rtl/pdp8_panel_pkg.sv
// Shared constants, channel indices and repeat-FSM encoding for the PDP8 front-panel buttons.
package pdp8_panel_pkg;

   // Channel positions on the nBUT bus
   localparam int unsigned CH_RUN   = 0;
   localparam int unsigned CH_CLEAR = 1;
   localparam int unsigned CH_SST   = 2;

   // Default timing at 25 MHz
   localparam int unsigned DEB_10MS_25MHZ   = 250000;
   localparam int unsigned REP_DELAY_25MHZ  = 12500000;
   localparam int unsigned REP_PERIOD_25MHZ = 2500000;

   // Auto-repeat state: released, waiting for first repeat, repeating
   typedef enum logic [1:0] {
      REL   = 2'd0,
      DELAY = 2'd1,
      RPT   = 2'd2
   } rpt_state_t;

   // Counter width able to hold 0..n-1, never narrower than one bit
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/panel_debounce_ch.sv
// One front-panel button: synchronizer, debounce counter, press/release strobes and optional auto-repeat.
module panel_debounce_ch
   import pdp8_panel_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEB_10MS_25MHZ,
   parameter int unsigned REPEAT_DELAY    = REP_DELAY_25MHZ,
   parameter int unsigned REPEAT_PERIOD   = REP_PERIOD_25MHZ,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic nRESET,
   input  logic nBUT,
   output logic pressed,
   output logic press_pulse,
   output logic release_pulse
);

   localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int unsigned RW = cnt_width(max_u(REPEAT_DELAY, REPEAT_PERIOD));

   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   logic          s1;
   logic          s2;
   logic          stable;
   logic [DW-1:0] dcnt;
   logic [DW-1:0] dcnt_nxt;
   rpt_state_t    state;
   rpt_state_t    state_nxt;
   logic [RW-1:0] rcnt;
   logic [RW-1:0] rcnt_nxt;

   logic raw_pressed_c;
   logic differ_c;
   logic flip_c;
   logic rise_c;
   logic fall_c;
   logic rpt_fire_c;

   // Two-flop synchronizer; resets to the released (high) level
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
      end else begin
         s1 <= nBUT;
         s2 <= s1;
      end
   end

   // Debounce: count consecutive disagreeing samples, accept the change on the last one
   always_comb begin
      raw_pressed_c = ~s2;
      differ_c      = raw_pressed_c ^ stable;
      flip_c        = differ_c && (dcnt == DEB_LAST);
      rise_c        = flip_c && !stable;
      fall_c        = flip_c && stable;
      dcnt_nxt      = '0;
      if (differ_c && !flip_c) begin
         dcnt_nxt = dcnt + DW'(1);
      end
   end

   // Auto-repeat next state; a release always wins over a pending repeat
   always_comb begin
      state_nxt  = state;
      rcnt_nxt   = rcnt;
      rpt_fire_c = 1'b0;
      case (state)
         REL: begin
            rcnt_nxt = '0;
            if (rise_c && REPEAT_EN) begin
               state_nxt = DELAY;
            end
         end
         DELAY: begin
            if (fall_c) begin
               state_nxt = REL;
               rcnt_nxt  = '0;
            end else if (rcnt == DLY_LAST) begin
               rpt_fire_c = 1'b1;
               rcnt_nxt   = '0;
               state_nxt  = RPT;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         RPT: begin
            if (fall_c) begin
               state_nxt = REL;
               rcnt_nxt  = '0;
            end else if (rcnt == PER_LAST) begin
               rpt_fire_c = 1'b1;
               rcnt_nxt   = '0;
            end else begin
               rcnt_nxt = rcnt + RW'(1);
            end
         end
         default: begin
            state_nxt = REL;
            rcnt_nxt  = '0;
         end
      endcase
   end

   // Repeat FSM state register
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         state <= REL;
         rcnt  <= '0;
      end else begin
         state <= state_nxt;
         rcnt  <= rcnt_nxt;
      end
   end

   // Debounced level, debounce counter and the one-cycle strobes
   always_ff @(posedge clk or negedge nRESET) begin
      if (!nRESET) begin
         stable        <= 1'b0;
         dcnt          <= '0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         dcnt          <= dcnt_nxt;
         press_pulse   <= rise_c | rpt_fire_c;
         release_pulse <= fall_c;
         if (flip_c) begin
            stable <= ~stable;
         end
      end
   end

   assign pressed = stable;

endmodule

// File: rtl/panel_switch_conditioner.sv
// Front-panel input stage: NCH independent debounced button channels feeding the PDP8 switch inputs.
module panel_switch_conditioner
   import pdp8_panel_pkg::*;
#(
   parameter int unsigned    NCH             = 3,
   parameter int unsigned    DEBOUNCE_CYCLES = DEB_10MS_25MHZ,
   parameter logic [NCH-1:0] REPEAT_MASK     = NCH'(1 << CH_SST),
   parameter int unsigned    REPEAT_DELAY    = REP_DELAY_25MHZ,
   parameter int unsigned    REPEAT_PERIOD   = REP_PERIOD_25MHZ
) (
   input  logic           clk,
   input  logic           nRESET,
   input  logic [NCH-1:0] nBUT,
   output logic [NCH-1:0] pressed,
   output logic [NCH-1:0] press_pulse,
   output logic [NCH-1:0] release_pulse
);

   // One conditioner per button; auto-repeat enabled per channel from the mask
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      panel_debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD),
         .REPEAT_EN       (REPEAT_MASK[i])
      ) u_ch (
         .clk           (clk),
         .nRESET        (nRESET),
         .nBUT          (nBUT[i]),
         .pressed       (pressed[i]),
         .press_pulse   (press_pulse[i]),
         .release_pulse (release_pulse[i])
      );
   end

endmodule

// File: tb/tb_panel_switch_conditioner.sv
// Scoreboard bench for panel_switch_conditioner with short debounce and repeat timing.
module tb_panel_switch_conditioner;
   import pdp8_panel_pkg::*;

   localparam int unsigned    NCH  = 3;
   localparam int unsigned    DEB  = 4;
   localparam int unsigned    RDLY = 8;
   localparam int unsigned    RPER = 3;
   localparam logic [NCH-1:0] MASK = 3'b100;
   // negedge where the pin is driven -> negedge where pressed/pulse are seen
   localparam int             LAT  = int'(DEB) + 2;

   typedef struct {
      int at;
      int ch;
      int kind;   // 0 = press_pulse, 1 = release_pulse
   } ev_t;

   logic           clk;
   logic           nRESET;
   logic [NCH-1:0] nBUT;
   logic [NCH-1:0] pressed;
   logic [NCH-1:0] press_pulse;
   logic [NCH-1:0] release_pulse;

   int  cyc      = 0;
   int  n_checks = 0;
   int  n_errors = 0;
   ev_t exp_q[$];

   panel_switch_conditioner #(
      .NCH             (NCH),
      .DEBOUNCE_CYCLES (DEB),
      .REPEAT_MASK     (MASK),
      .REPEAT_DELAY    (RDLY),
      .REPEAT_PERIOD   (RPER)
   ) dut (
      .clk           (clk),
      .nRESET        (nRESET),
      .nBUT          (nBUT),
      .pressed       (pressed),
      .press_pulse   (press_pulse),
      .release_pulse (release_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected pulses for a press seen by the synchronizer from the next edge on
   task automatic push_press(input int ch);
      ev_t e;
      int  t0;
      t0     = cyc + LAT;
      e.ch   = ch;
      e.kind = 0;
      e.at   = t0;
      exp_q.push_back(e);
      if (MASK[ch]) begin
         e.at = t0 + int'(RDLY);
         exp_q.push_back(e);
         e.at = t0 + int'(RDLY) + int'(RPER);
         exp_q.push_back(e);
         e.at = t0 + int'(RDLY) + 2 * int'(RPER);
         exp_q.push_back(e);
      end
   endtask

   task automatic drive_press(input int ch);
      nBUT[ch] = 1'b0;
      push_press(ch);
   endtask

   task automatic drive_release(input int ch);
      ev_t e;
      nBUT[ch] = 1'b1;
      e.at   = cyc + LAT;
      e.ch   = ch;
      e.kind = 1;
      exp_q.push_back(e);
   endtask

   // Pulse monitor: every strobe seen must match the head of the scoreboard
   always @(negedge clk) begin
      for (int ch = 0; ch < int'(NCH); ch++) begin
         for (int k = 0; k < 2; k++) begin
            logic hit;
            ev_t  e;
            hit = (k == 0) ? press_pulse[ch] : release_pulse[ch];
            if (hit === 1'b1) begin
               if (exp_q.size() == 0) begin
                  check($sformatf("spurious_pulse_ch%0d_kind%0d", ch, k), 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("pulse_cycle", 32'(cyc), 32'(e.at));
                  check("pulse_channel", 32'(ch), 32'(e.ch));
                  check("pulse_kind", 32'(k), 32'(e.kind));
                  check("level_at_pulse", 32'(pressed[ch]), (k == 0) ? 32'd1 : 32'd0);
               end
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nRESET = 1'b0;
      nBUT   = '1;
      wait_cyc(3);
      check("rst_pressed", 32'(pressed), 32'd0);
      check("rst_press_pulse", 32'(press_pulse), 32'd0);
      check("rst_release_pulse", 32'(release_pulse), 32'd0);
      nRESET = 1'b1;
      wait_cyc(5);

      // Clean press and release on RUN (no auto-repeat: exactly one press pulse)
      drive_press(CH_RUN);
      wait_cyc(LAT - 1);
      check("run_not_yet", 32'(pressed[CH_RUN]), 32'd0);
      wait_cyc(1);
      check("run_pressed", 32'(pressed[CH_RUN]), 32'd1);
      check("run_press_pulse", 32'(press_pulse[CH_RUN]), 32'd1);
      wait_cyc(1);
      check("run_pulse_width", 32'(press_pulse[CH_RUN]), 32'd0);
      wait_cyc(20);
      check("run_held", 32'(pressed[CH_RUN]), 32'd1);
      drive_release(CH_RUN);
      wait_cyc(LAT);
      check("run_released", 32'(pressed[CH_RUN]), 32'd0);
      check("run_release_pulse", 32'(release_pulse[CH_RUN]), 32'd1);
      wait_cyc(5);

      // Bouncing CLEAR: every excursion shorter than the debounce window
      for (int i = 0; i < 5; i++) begin
         nBUT[CH_CLEAR] = 1'b0;
         wait_cyc(2);
         nBUT[CH_CLEAR] = 1'b1;
         wait_cyc(2);
      end
      wait_cyc(10);
      check("bounce_pressed", 32'(pressed[CH_CLEAR]), 32'd0);

      // SST hold: press, repeats at +8/+11/+14, release before the next one
      drive_press(CH_SST);
      wait_cyc(16);
      drive_release(CH_SST);
      wait_cyc(30);
      check("sst_released", 32'(pressed[CH_SST]), 32'd0);

      // Reset during DELAY, button still held across reset release
      drive_press(CH_SST);
      wait_cyc(LAT + 3);
      check("sst_pressed_pre_rst", 32'(pressed[CH_SST]), 32'd1);
      nRESET = 1'b0;
      exp_q.delete();
      #1;
      check("async_rst_pressed", 32'(pressed), 32'd0);
      check("async_rst_press_pulse", 32'(press_pulse), 32'd0);
      check("async_rst_release_pulse", 32'(release_pulse), 32'd0);
      wait_cyc(3);
      nRESET = 1'b1;
      push_press(CH_SST);
      wait_cyc(LAT - 1);
      check("sst_rerise_not_yet", 32'(pressed[CH_SST]), 32'd0);
      wait_cyc(1);
      check("sst_rerise", 32'(pressed[CH_SST]), 32'd1);
      check("sst_rerise_pulse", 32'(press_pulse[CH_SST]), 32'd1);
      wait_cyc(10);
      drive_release(CH_SST);
      wait_cyc(30);

      // Simultaneous RUN + CLEAR
      drive_press(CH_RUN);
      drive_press(CH_CLEAR);
      wait_cyc(LAT);
      check("sim_pressed", 32'(pressed), 32'd3);
      check("sim_press_pulse", 32'(press_pulse), 32'd3);
      wait_cyc(3);
      drive_release(CH_RUN);
      drive_release(CH_CLEAR);
      wait_cyc(LAT);
      check("sim_release_pulse", 32'(release_pulse), 32'd3);
      check("sim_released", 32'(pressed), 32'd0);
      wait_cyc(10);

      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
